// File: rtl/spi_slave_rx_tx.sv
// SPI slave endpoint: synchronises SCK/CS/MOSI into the clk domain and
// shifts DATA_W-bit frames MSB first in any of the four SPI modes.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   mode            {CPOL, CPHA}, taken while CS is high
//   sck, cs, mosi   raw SPI pins from the master (asynchronous to clk)
//   miso            serial data out, 0 while idle
//   tx_data, tx_wr  write port of the one-deep transmit holding register
//   tx_ready        holding register empty
//   rx_data         last complete received frame
//   rx_valid        one-cycle pulse when rx_data updates
//   busy            synchronised CS low
//   tx_ovf          sticky: write dropped because holding register was full
//   underrun        sticky: a frame started with the holding register empty
//   clr_flags       clears tx_ovf and underrun (a same-cycle set wins)
module spi_slave_rx_tx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              tx_ovf,
  output logic              underrun,
  input  logic              clr_flags
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sck_sync;
  logic [SYNC_STAGES-1:0]   cs_sync;
  logic [SYNC_STAGES-1:0]   mosi_sync;
  logic                     sck_q;
  logic [1:0]               mode_q;
  logic [CNT_W-1:0]         bit_cnt;
  logic [DATA_W-1:0]        shift_tx;
  logic [DATA_W-1:0]        shift_rx;
  logic [DATA_W-1:0]        hold_q;
  logic                     fill_q;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, lead_e, trail_e, sample_e, shift_e;
  logic [DATA_W-1:0] load_byte;

  // Pin synchronisers; CS resets to its inactive (high) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
    end else begin
      sck_sync  <= (sck_sync << 1) | SYNC_STAGES'(sck);
      cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(cs);
      mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
      sck_q     <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge classification from the latched mode
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign lead_e   = mode_q[1] ? sck_fall : sck_rise;
  assign trail_e  = mode_q[1] ? sck_rise : sck_fall;
  assign sample_e = mode_q[0] ? trail_e : lead_e;
  // CPHA=0: a trailing edge before the first sample is the tail of the
  // previous back-to-back frame and must not shift the new byte
  assign shift_e  = mode_q[0] ? lead_e : (trail_e & (bit_cnt != '0));

  assign load_byte = tx_ready ? '0 : hold_q;

  // Frame FSM, holding register and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= 2'b00;
      bit_cnt  <= '0;
      shift_tx <= '0;
      shift_rx <= '0;
      hold_q   <= '0;
      fill_q   <= 1'b0;
      miso     <= 1'b0;
      tx_ready <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      tx_ovf   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      busy     <= ~cs_s;

      if (clr_flags) begin
        tx_ovf   <= 1'b0;
        underrun <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          miso    <= 1'b0;
          bit_cnt <= '0;
          mode_q  <= mode;
          if (!cs_s) state <= S_LOAD;
        end

        S_LOAD: begin
          // fill_q remembers a zero fill; underrun is flagged only if the
          // frame actually starts clocking
          fill_q   <= tx_ready;
          tx_ready <= 1'b1;
          bit_cnt  <= '0;
          if (!mode_q[0]) begin
            miso     <= load_byte[DATA_W-1];
            shift_tx <= load_byte << 1;
          end else begin
            shift_tx <= load_byte;
          end
          state <= cs_s ? S_IDLE : S_SHIFT;
        end

        S_SHIFT: begin
          if (cs_s) begin
            // Abort: partial frame discarded
            state   <= S_IDLE;
            bit_cnt <= '0;
            miso    <= 1'b0;
          end else begin
            if (shift_e) begin
              miso     <= shift_tx[DATA_W-1];
              shift_tx <= shift_tx << 1;
            end
            if (sample_e) begin
              shift_rx <= {shift_rx[DATA_W-2:0], mosi_s};
              fill_q   <= 1'b0;
              if (fill_q) underrun <= 1'b1;
              if (bit_cnt == LAST_BIT) begin
                rx_data  <= {shift_rx[DATA_W-2:0], mosi_s};
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                state    <= S_LOAD;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase

      // A write in the LOAD cycle is accepted: LOAD takes the old byte
      if (tx_wr) begin
        if (tx_ready || (state == S_LOAD)) begin
          hold_q   <= tx_data;
          tx_ready <= 1'b0;
        end else begin
          tx_ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Directed bench for spi_slave_rx_tx: a simple SPI master model drives the
// pins, table vectors cover the four modes, hand sequences cover the corners.
module tb_spi_slave_rx_tx;

  localparam int unsigned DATA_W = 8;
  localparam int H = 6;  // SCK half period in clk cycles

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        mode = 2'b00;
  logic              sck = 1'b0;
  logic              cs = 1'b1;
  logic              mosi = 1'b0;
  logic              miso;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_wr = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              tx_ovf;
  logic              underrun;
  logic              clr_flags = 1'b0;

  int total = 0;
  int bad = 0;
  int rv_cnt = 0;

  always #5 clk = ~clk;

  spi_slave_rx_tx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sck(sck), .cs(cs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_wr(tx_wr), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .tx_ovf(tx_ovf),
    .underrun(underrun), .clr_flags(clr_flags)
  );

  always @(negedge clk) if (rx_valid) rv_cnt <= rv_cnt + 1;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] tx_pre;
    logic [7:0] mosi_b;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] b);
    tx_data = b;
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  // One frame from the master side; CS already low, SCK at CPOL
  task automatic xfer(input logic [1:0] m, input logic [7:0] tx, output logic [7:0] rx);
    logic [7:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!m[0]) begin
        mosi = tx[i];
        wait_clk(H);
        r[i] = miso;
        sck = ~m[1];
        wait_clk(H);
        sck = m[1];
      end else begin
        sck = ~m[1];
        mosi = tx[i];
        wait_clk(H);
        r[i] = miso;
        sck = m[1];
        wait_clk(H);
      end
    end
    rx = r;
  endtask

  task automatic idle_mode(input logic [1:0] m);
    mode = m;
    sck = m[1];
    wait_clk(8);
  endtask

  task automatic end_frame();
    wait_clk(H);
    cs = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    logic [7:0] got, got2;
    int rv0;

    vecs[0] = '{mode: 2'd0, tx_pre: 8'hAA, mosi_b: 8'hBB, exp_miso: 8'hAA, exp_rx: 8'hBB};
    vecs[1] = '{mode: 2'd1, tx_pre: 8'h72, mosi_b: 8'hBB, exp_miso: 8'h72, exp_rx: 8'hBB};
    vecs[2] = '{mode: 2'd2, tx_pre: 8'hC3, mosi_b: 8'hBB, exp_miso: 8'hC3, exp_rx: 8'hBB};
    vecs[3] = '{mode: 2'd3, tx_pre: 8'h5D, mosi_b: 8'hBB, exp_miso: 8'h5D, exp_rx: 8'hBB};
    vecs[4] = '{mode: 2'd0, tx_pre: 8'h3C, mosi_b: 8'h81, exp_miso: 8'h3C, exp_rx: 8'h81};

    // Reset values
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_ovf", 32'(tx_ovf), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);

    // Single frames in each mode
    for (int v = 0; v < 5; v++) begin
      idle_mode(vecs[v].mode);
      write_tx(vecs[v].tx_pre);
      chk("vec_tx_ready_full", 32'(tx_ready), 32'd0);
      rv0 = rv_cnt;
      cs = 1'b0;
      wait_clk(8);
      chk("vec_busy", 32'(busy), 32'd1);
      chk("vec_tx_ready_load", 32'(tx_ready), 32'd1);
      xfer(vecs[v].mode, vecs[v].mosi_b, got);
      end_frame();
      chk("vec_master_rx", 32'(got), 32'(vecs[v].exp_miso));
      chk("vec_rx_data", 32'(rx_data), 32'(vecs[v].exp_rx));
      chk("vec_rx_pulses", 32'(rv_cnt - rv0), 32'd1);
      chk("vec_tx_ovf", 32'(tx_ovf), 32'd0);
      chk("vec_underrun", 32'(underrun), 32'd0);
      chk("vec_busy_idle", 32'(busy), 32'd0);
      chk("vec_miso_idle", 32'(miso), 32'd0);
    end

    // Back-to-back frames with CS held low
    idle_mode(2'd0);
    write_tx(8'h11);
    cs = 1'b0;
    wait_clk(8);
    write_tx(8'h22);
    chk("b2b_tx_ready", 32'(tx_ready), 32'd0);
    rv0 = rv_cnt;
    xfer(2'd0, 8'h5A, got);
    chk("b2b_rx_first", 32'(rx_data), 32'h5A);
    chk("b2b_pulses_first", 32'(rv_cnt - rv0), 32'd1);
    xfer(2'd0, 8'hA5, got2);
    end_frame();
    chk("b2b_miso_first", 32'(got), 32'h11);
    chk("b2b_miso_second", 32'(got2), 32'h22);
    chk("b2b_rx_second", 32'(rx_data), 32'hA5);
    chk("b2b_pulses", 32'(rv_cnt - rv0), 32'd2);
    chk("b2b_underrun", 32'(underrun), 32'd0);
    chk("b2b_tx_ready_end", 32'(tx_ready), 32'd1);

    // Underrun: frame with an empty holding register
    cs = 1'b0;
    wait_clk(8);
    xfer(2'd0, 8'h0F, got);
    end_frame();
    chk("udr_miso", 32'(got), 32'h00);
    chk("udr_flag", 32'(underrun), 32'd1);
    chk("udr_rx_data", 32'(rx_data), 32'h0F);

    // Overflow, then clear with a simultaneous set, then plain clear
    write_tx(8'h99);
    chk("ovf_tx_ready", 32'(tx_ready), 32'd0);
    chk("ovf_none_yet", 32'(tx_ovf), 32'd0);
    write_tx(8'h77);
    chk("ovf_flag", 32'(tx_ovf), 32'd1);
    clr_flags = 1'b1;
    write_tx(8'h55);
    clr_flags = 1'b0;
    chk("ovf_set_wins", 32'(tx_ovf), 32'd1);
    chk("udr_cleared", 32'(underrun), 32'd0);
    clr_flags = 1'b1;
    wait_clk(1);
    clr_flags = 1'b0;
    chk("ovf_cleared", 32'(tx_ovf), 32'd0);
    chk("udr_still_clear", 32'(underrun), 32'd0);

    // Abort after four SCK edges; the held 0x99 is consumed
    rv0 = rv_cnt;
    cs = 1'b0;
    wait_clk(8);
    chk("abort_tx_ready", 32'(tx_ready), 32'd1);
    for (int k = 0; k < 2; k++) begin
      mosi = 1'b1;
      wait_clk(H);
      sck = 1'b1;
      wait_clk(H);
      sck = 1'b0;
    end
    end_frame();
    chk("abort_pulses", 32'(rv_cnt - rv0), 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'h0F);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_miso", 32'(miso), 32'd0);
    chk("abort_underrun", 32'(underrun), 32'd0);
    write_tx(8'h3C);
    cs = 1'b0;
    wait_clk(8);
    xfer(2'd0, 8'hE7, got);
    end_frame();
    chk("post_abort_miso", 32'(got), 32'h3C);
    chk("post_abort_rx", 32'(rx_data), 32'hE7);
    chk("post_abort_pulses", 32'(rv_cnt - rv0), 32'd1);

    // Reset mid-frame: 0x2A puts bit 5 (=1) on MISO after two shifts
    write_tx(8'h2A);
    write_tx(8'h01);
    cs = 1'b0;
    wait_clk(8);
    for (int k = 0; k < 3; k++) begin
      mosi = 1'b1;
      wait_clk(H);
      sck = 1'b1;
      wait_clk(H);
      if (k < 2) sck = 1'b0;
    end
    chk("pre_rst_miso", 32'(miso), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_ovf", 32'(tx_ovf), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_rx_data", 32'(rx_data), 32'h00);
    chk("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_ovf", 32'(tx_ovf), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    cs = 1'b1;
    sck = 1'b0;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(8);
    rv0 = rv_cnt;
    write_tx(8'h6E);
    cs = 1'b0;
    wait_clk(8);
    xfer(2'd0, 8'h93, got);
    end_frame();
    chk("post_rst_miso", 32'(got), 32'h6E);
    chk("post_rst_rx", 32'(rx_data), 32'h93);
    chk("post_rst_pulses", 32'(rv_cnt - rv0), 32'd1);
    chk("post_rst_underrun", 32'(underrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
